prog_sync_fifo: RTL and testbench

PROG_SYNC_FIFO -- requirements
Module: prog_sync_fifo

---
 rtl/prog_sync_fifo.sv | 100 ++++++++++
 tb/tb_prog_sync_fifo.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/prog_sync_fifo.sv
// Single-clock FIFO with show-ahead read data and programmable almost-full/almost-empty levels.
// Sticky overflow/underflow flags are built only when PROG_SYNC_FIFO_ERR_FLAGS_EN is defined.
module prog_sync_fifo #(
  parameter int WIDTH     = 16,
  parameter int ADDR_BITS = 3,
  parameter int AF_LEVEL  = 6,
  parameter int AE_LEVEL  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     wdata,
  input  logic                 wen,
  input  logic                 ren,
  input  logic                 clr_err,
  output logic [WIDTH-1:0]     rdata,
  output logic                 is_full,
  output logic                 is_empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic [ADDR_BITS:0]   count,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int                 DEPTH    = 1 << ADDR_BITS;
  localparam logic [ADDR_BITS:0] C_DEPTH  = (ADDR_BITS + 1)'(DEPTH);
  localparam logic [ADDR_BITS:0] C_AF     = (ADDR_BITS + 1)'(AF_LEVEL);
  localparam logic [ADDR_BITS:0] C_AE     = (ADDR_BITS + 1)'(AE_LEVEL);
  localparam logic [ADDR_BITS:0] C_ONE    = (ADDR_BITS + 1)'(1);
  localparam logic [ADDR_BITS-1:0] C_PTR1 = ADDR_BITS'(1);

  logic [WIDTH-1:0]     r_mem [DEPTH];
  logic [ADDR_BITS-1:0] r_wr_ptr;
  logic [ADDR_BITS-1:0] r_rd_ptr;
  logic [ADDR_BITS:0]   r_count;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_wr_acc;
  logic                 w_rd_acc;

  // Status flags depend on the registered count only, never on wen/ren.
  assign w_full       = (r_count == C_DEPTH);
  assign w_empty      = (r_count == '0);
  assign w_wr_acc     = wen & ~w_full;
  assign w_rd_acc     = ren & ~w_empty;

  assign is_full      = w_full;
  assign is_empty     = w_empty;
  assign almost_full  = (r_count >= C_AF);
  assign almost_empty = (r_count <= C_AE);
  assign count        = r_count;
  assign rdata        = r_mem[r_rd_ptr];

  // NOTE: the storage array has no reset; clearing the pointers and count is what discards data.
  always_ff @(posedge clk) begin
    if (w_wr_acc) r_mem[r_wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + C_PTR1;
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + C_PTR1;
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + C_ONE;
        2'b01:   r_count <= r_count - C_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef PROG_SYNC_FIFO_ERR_FLAGS_EN
  logic r_overflow;
  logic r_underflow;

  // A new error event wins over a coincident clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= (wen & w_full)  | (r_overflow  & ~clr_err);
      r_underflow <= (ren & w_empty) | (r_underflow & ~clr_err);
    end
  end

  assign overflow  = r_overflow;
  assign underflow = r_underflow;
`else
  logic w_unused;

  assign w_unused  = clr_err;
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_prog_sync_fifo.sv
// Directed self-checking bench for prog_sync_fifo (WIDTH=16, ADDR_BITS=3, AF=6, AE=2).
// Inputs change on the falling edge; outputs are sampled on the falling edge after each rising edge.
module tb_prog_sync_fifo;

`ifdef PROG_SYNC_FIFO_ERR_FLAGS_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [15:0] wdata;
  logic        wen;
  logic        ren;
  logic        clr_err;
  logic [15:0] rdata;
  logic        is_full;
  logic        is_empty;
  logic        almost_full;
  logic        almost_empty;
  logic [3:0]  count;
  logic        overflow;
  logic        underflow;

  int n_total = 0;
  int n_bad   = 0;

  prog_sync_fifo #(
    .WIDTH(16), .ADDR_BITS(3), .AF_LEVEL(6), .AE_LEVEL(2)
  ) dut (
    .clk(clk), .rst(rst), .wdata(wdata), .wen(wen), .ren(ren), .clr_err(clr_err),
    .rdata(rdata), .is_full(is_full), .is_empty(is_empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: got=running exp=finished");
    $fatal(1, "bench timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One rising edge with the given controls, then back to idle at the falling edge.
  task automatic cycle(input logic w, input logic r, input logic [15:0] d, input logic c);
    wen = w; ren = r; wdata = d; clr_err = c;
    @(negedge clk);
    wen = 1'b0; ren = 1'b0; clr_err = 1'b0;
  endtask

  task automatic check_flags(input string tag, input logic [3:0] n);
    check({tag, ".count"}, count, n);
    check({tag, ".empty"}, is_empty, n == 0);
    check({tag, ".full"}, is_full, n == 8);
    check({tag, ".ae"}, almost_empty, n <= 2);
    check({tag, ".af"}, almost_full, n >= 6);
  endtask

  initial begin
    rst = 1'b0; wen = 1'b0; ren = 1'b0; clr_err = 1'b0; wdata = '0;

    // Reset state, and a write held off while reset is still low at the edge.
    wen = 1'b1; wdata = 16'hDEAD;
    @(negedge clk);
    wen = 1'b0;
    check_flags("rst", 4'd0);
    check("rst.ovf", overflow, 1'b0);
    check("rst.unf", underflow, 1'b0);
    rst = 1'b1;

    // Fill 0x0001..0x0008, then drain in order.
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b1, 1'b0, 16'(i), 1'b0);
      check_flags($sformatf("fill%0d", i), 4'(i));
      check("fill.head", rdata, 16'h0001);
    end
    for (int i = 1; i <= 8; i++) begin
      check($sformatf("drain%0d.rdata", i), rdata, 16'(i));
      cycle(1'b0, 1'b1, 16'h0, 1'b0);
      check($sformatf("drain%0d.count", i), count, 4'(8 - i));
    end
    check("drain.empty", is_empty, 1'b1);
    check("drain.unf", underflow, 1'b0);

    // Full with simultaneous read and write: read wins, 0xBEEF is dropped.
    for (int i = 1; i <= 8; i++) cycle(1'b1, 1'b0, 16'h0010 + 16'(i), 1'b0);
    check("full.is_full", is_full, 1'b1);
    cycle(1'b1, 1'b1, 16'hBEEF, 1'b0);
    check("fullrw.count", count, 4'd7);
    check("fullrw.rdata", rdata, 16'h0012);
    check("fullrw.ovf", overflow, ERR_EN);
    for (int k = 2; k <= 8; k++) begin
      check($sformatf("fullrw.out%0d", k), rdata, 16'h0010 + 16'(k));
      cycle(1'b0, 1'b1, 16'h0, 1'b0);
    end
    check("fullrw.empty", is_empty, 1'b1);
    check("fullrw.ovf_hold", overflow, ERR_EN);
    cycle(1'b0, 1'b0, 16'h0, 1'b1);
    check("ovf.clr", overflow, 1'b0);

    // Empty with simultaneous read and write: write wins.
    cycle(1'b1, 1'b1, 16'h1234, 1'b0);
    check("emptyrw.count", count, 4'd1);
    check("emptyrw.rdata", rdata, 16'h1234);
    check("emptyrw.unf", underflow, ERR_EN);
    cycle(1'b0, 1'b1, 16'h0, 1'b0);
    check("emptyrw.drain", count, 4'd0);
    check("unf.hold", underflow, ERR_EN);

    // Clear, then clear coincident with a fresh underflow event.
    cycle(1'b0, 1'b0, 16'h0, 1'b1);
    check("unf.clr", underflow, 1'b0);
    cycle(1'b0, 1'b1, 16'h0, 1'b1);
    check("unf.set_wins", underflow, ERR_EN);
    check("unf.set_cnt", count, 4'd0);
    cycle(1'b0, 1'b0, 16'h0, 1'b1);
    check("unf.clr2", underflow, 1'b0);

    // Streaming at constant occupancy 4 across several pointer wraps.
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 16'h0100 + 16'(i), 1'b0);
    for (int k = 0; k < 20; k++) begin
      check($sformatf("stream%0d.rdata", k), rdata, 16'h0100 + 16'(k));
      cycle(1'b1, 1'b1, 16'h0104 + 16'(k), 1'b0);
      check($sformatf("stream%0d.count", k), count, 4'd4);
    end
    check("stream.tail", rdata, 16'h0114);

    // Asynchronous reset between edges at count 5.
    cycle(1'b1, 1'b0, 16'h0200, 1'b0);
    check_flags("pre_rst", 4'd5);
    #2 rst = 1'b0;
    #1 check_flags("mid_rst", 4'd0);
    check("mid_rst.ovf", overflow, 1'b0);
    check("mid_rst.unf", underflow, 1'b0);
    #1 rst = 1'b1;
    @(negedge clk);
    check("post_rst.count", count, 4'd0);
    cycle(1'b1, 1'b0, 16'hA5A5, 1'b0);
    check("post_rst.rdata", rdata, 16'hA5A5);
    check_flags("post_rst", 4'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
